// File: rtl/pc_next_fetch_pkg.sv
// rtl/pc_next_fetch_pkg.sv - shared control codes for the PC/fetch stage
package pc_next_fetch_pkg;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10,
        TRAP  = 2'b11
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/pc_next_fetch_next_pc_mux.sv
// rtl/pc_next_fetch_next_pc_mux.sv - next-PC selection and misalignment flag
module pc_next_fetch_next_pc_mux
    import pc_next_fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       pc_sel,
    input  logic [WIDTH-1:0] pc_plus_4,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] next_pc,
    output logic             misaligned
);

    always_comb begin
        next_pc = pc_plus_4;
        case (pc_sel)
            PC_BR:   next_pc = branch_target;
            PC_JMP:  next_pc = jump_target;
            default: next_pc = pc_plus_4;
        endcase
    end

    // No compressed ISA: any target not on a 4-byte boundary is a fault
    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/pc_next_fetch.sv
// rtl/pc_next_fetch.sv - PC register, fetch sequencer, trap redirect and retire counter
module pc_next_fetch
    import pc_next_fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'(DEFAULT_TRAP_VEC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       PCSel,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic [WIDTH-1:0] JumpTarget,
    input  logic             Stall,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PC_Plus_4,
    output logic             InstrValid,
    output logic             MisalignTrap,
    output logic [WIDTH-1:0] TrapEPC,
    output logic [WIDTH-1:0] TrapTVal,
    output logic [WIDTH-1:0] InstRet
);

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instret_q, instret_d;
    logic [WIDTH-1:0] trap_epc_q, trap_epc_d;
    logic [WIDTH-1:0] trap_tval_q, trap_tval_d;
    logic [WIDTH-1:0] next_pc;
    logic             next_misaligned;

    assign PC_Plus_4 = pc_q + WIDTH'(4);

    pc_next_fetch_next_pc_mux #(.WIDTH(WIDTH)) u_next_pc_mux (
        .pc_sel        (PCSel),
        .pc_plus_4     (PC_Plus_4),
        .branch_target (BranchTarget),
        .jump_target   (JumpTarget),
        .next_pc       (next_pc),
        .misaligned    (next_misaligned)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instret_d    = instret_q;
        trap_epc_d   = trap_epc_q;
        trap_tval_d  = trap_tval_q;
        imem_req     = 1'b0;
        InstrValid   = 1'b0;
        MisalignTrap = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_d = EXEC;
            end
            EXEC: begin
                InstrValid = 1'b1;
                if (!Stall) begin
                    if (next_misaligned) begin
                        state_d     = TRAP;
                        trap_epc_d  = pc_q;
                        trap_tval_d = next_pc;
                    end else begin
                        state_d   = FETCH;
                        pc_d      = next_pc;
                        instret_d = instret_q + WIDTH'(1);
                    end
                end
            end
            TRAP: begin
                MisalignTrap = 1'b1;
                pc_d         = TRAP_VEC;
                state_d      = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from state, so an async reset clears them without a clock edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            instret_q   <= '0;
            trap_epc_q  <= '0;
            trap_tval_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instret_q   <= instret_d;
            trap_epc_q  <= trap_epc_d;
            trap_tval_q <= trap_tval_d;
        end
    end

    assign PC        = pc_q;
    assign imem_addr = pc_q;
    assign InstRet   = instret_q;
    assign TrapEPC   = trap_epc_q;
    assign TrapTVal  = trap_tval_q;

endmodule

// File: tb/tb_pc_next_fetch.sv
// tb/tb_pc_next_fetch.sv - directed scoreboard bench for pc_next_fetch
module tb_pc_next_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  PCSel;
    logic [31:0] BranchTarget;
    logic [31:0] JumpTarget;
    logic        Stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] PC;
    logic [31:0] PC_Plus_4;
    logic        InstrValid;
    logic        MisalignTrap;
    logic [31:0] TrapEPC;
    logic [31:0] TrapTVal;
    logic [31:0] InstRet;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_pc, m_ret, m_epc, m_tval;

    pc_next_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .PCSel        (PCSel),
        .BranchTarget (BranchTarget),
        .JumpTarget   (JumpTarget),
        .Stall        (Stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .PC           (PC),
        .PC_Plus_4    (PC_Plus_4),
        .InstrValid   (InstrValid),
        .MisalignTrap (MisalignTrap),
        .TrapEPC      (TrapEPC),
        .TrapTVal     (TrapTVal),
        .InstRet      (InstRet)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for a request, compare against the scoreboard, then ack after extra wait cycles
    task automatic do_fetch(input int wait_cycles);
        logic [31:0] exp_addr;
        int n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        check("req_seen", {31'd0, imem_req}, 32'd1);
        exp_addr = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check("fetch_addr", imem_addr, exp_addr);
        for (int i = 0; i < wait_cycles; i++) begin
            imem_ack = 1'b0;
            step();
            check("req_hold", {31'd0, imem_req}, 32'd1);
            check("addr_hold", imem_addr, exp_addr);
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        check("instr_valid", {31'd0, InstrValid}, 32'd1);
        check("req_low_exec", {31'd0, imem_req}, 32'd0);
    endtask

    task automatic exec(input logic [1:0] sel, input logic [31:0] br, input logic [31:0] jmp,
                        input int stall_cycles, input bit spurious_ack);
        logic [31:0] nxt;
        PCSel        = sel;
        BranchTarget = br;
        JumpTarget   = jmp;
        nxt = (sel == 2'b01) ? br : (sel == 2'b10) ? jmp : m_pc + 32'd4;
        check("pc_plus_4", PC_Plus_4, m_pc + 32'd4);
        for (int i = 0; i < stall_cycles; i++) begin
            Stall    = 1'b1;
            imem_ack = spurious_ack && (i == 1);
            step();
            check("stall_pc", PC, m_pc);
            check("stall_ret", InstRet, m_ret);
            check("stall_valid", {31'd0, InstrValid}, 32'd1);
            check("stall_noreq", {31'd0, imem_req}, 32'd0);
        end
        Stall    = 1'b0;
        imem_ack = 1'b0;
        if (nxt[1:0] == 2'b00) begin
            m_pc = nxt;
            m_ret++;
            exp_q.push_back(nxt);
            step();
            check("adv_pc", PC, m_pc);
            check("adv_ret", InstRet, m_ret);
            check("adv_notrap", {31'd0, MisalignTrap}, 32'd0);
            check("epc_hold", TrapEPC, m_epc);
            check("tval_hold", TrapTVal, m_tval);
        end else begin
            m_epc  = m_pc;
            m_tval = nxt;
            step();
            check("trap_pulse", {31'd0, MisalignTrap}, 32'd1);
            check("trap_epc", TrapEPC, m_epc);
            check("trap_tval", TrapTVal, m_tval);
            check("trap_ret", InstRet, m_ret);
            m_pc = 32'h0000_0100;
            exp_q.push_back(m_pc);
            step();
            check("trap_done", {31'd0, MisalignTrap}, 32'd0);
            check("trap_pc", PC, m_pc);
            check("trap_ret2", InstRet, m_ret);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc   = 32'h0;
        m_ret  = 32'h0;
        m_epc  = 32'h0;
        m_tval = 32'h0;
        exp_q.push_back(32'h0);
    endtask

    task automatic check_reset_vals();
        check("rst_pc", PC, 32'h0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, InstrValid}, 32'd0);
        check("rst_trap", {31'd0, MisalignTrap}, 32'd0);
        check("rst_epc", TrapEPC, 32'h0);
        check("rst_tval", TrapTVal, 32'h0);
        check("rst_ret", InstRet, 32'h0);
    endtask

    initial begin
        rst = 1'b1; PCSel = 2'b00; BranchTarget = '0; JumpTarget = '0;
        Stall = 1'b0; imem_ack = 1'b0;
        step(); step();
        check_reset_vals();
        model_reset();
        rst = 1'b0;
        check("idle_noreq", {31'd0, imem_req}, 32'd0);

        do_fetch(0);
        exec(2'b00, 32'h0, 32'h0, 0, 1'b0);
        do_fetch(0);
        exec(2'b10, 32'h0, 32'h0000_0200, 0, 1'b0);
        do_fetch(0);
        exec(2'b01, 32'h0000_0102, 32'h0, 0, 1'b0);
        do_fetch(3);
        exec(2'b00, 32'h0, 32'h0, 5, 1'b1);
        do_fetch(1);
        exec(2'b11, 32'h0000_0003, 32'h0000_0002, 0, 1'b0);
        do_fetch(0);
        exec(2'b10, 32'h0, 32'hFFFF_FFFC, 0, 1'b0);
        do_fetch(2);
        exec(2'b00, 32'h0, 32'h0, 0, 1'b0);
        check("wrap_pc", PC, 32'h0);
        do_fetch(0);
        exec(2'b10, 32'h0, 32'h0000_0202, 2, 1'b0);

        // Reset lands mid-fetch, between clock edges, with an ack on the bus
        check("prereset_req", {31'd0, imem_req}, 32'd1);
        step();
        #2;
        imem_ack = 1'b1;
        rst = 1'b1;
        #1;
        check_reset_vals();
        step();
        check_reset_vals();
        imem_ack = 1'b0;
        model_reset();
        rst = 1'b0;
        check("restart_idle", {31'd0, imem_req}, 32'd0);
        do_fetch(0);
        exec(2'b00, 32'h0, 32'h0, 0, 1'b0);
        check("restart_pc", PC, 32'h4);
        check("restart_ret", InstRet, 32'h1);
        check("queue_left", exp_q.size(), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
